// File: rtl/vigna_c_fetch_aligner.sv
// Instruction fetch aligner: buffers fetched words as halfword parcels and issues
// 16-bit compressed or (possibly word-straddling) 32-bit instructions, with redirect support.
module vigna_c_fetch_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        i_valid,
    input  logic        i_ready,
    output logic [31:0] i_addr,
    input  logic [31:0] i_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        inst_is_c
);

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        DISCARD = 1'b1
    } state_t;

    state_t      state_r, state_s;
    logic [15:0] q_r [4];
    logic [15:0] q_s [4];
    logic [2:0]  count_r, count_s;
    logic [31:0] head_pc_r, head_pc_s;
    logic [31:0] fetch_pc_r, fetch_pc_s;
    logic        drop_first_r, drop_first_s;
    logic        i_valid_r, i_valid_s;
    logic [31:0] i_addr_r, i_addr_s;

    logic        head_c_s;
    logic        issue_s;
    logic [31:0] inst_data_s;
    logic [1:0]  deq_s;
    logic [2:0]  mid_s;

    // Issue decision, taken purely from the registered queue contents.
    always_comb begin
        head_c_s = (q_r[0][1:0] != 2'b11);
        if (state_r != RUN) begin
            issue_s = 1'b0;
        end else if (head_c_s) begin
            issue_s = (count_r >= 3'd1);
        end else begin
            issue_s = (count_r >= 3'd2);
        end
        if (head_c_s) begin
            inst_data_s = {16'h0000, q_r[0]};
        end else begin
            inst_data_s = {q_r[1], q_r[0]};
        end
    end

    assign inst_valid = issue_s;
    assign inst_data  = inst_data_s;
    assign inst_pc    = head_pc_r;
    assign inst_is_c  = head_c_s;
    assign i_valid    = i_valid_r;
    assign i_addr     = i_addr_r;

    // Next-state: redirect, discard of a stale response, dequeue/enqueue and fetch issue.
    always_comb begin
        state_s      = state_r;
        q_s          = q_r;
        count_s      = count_r;
        head_pc_s    = head_pc_r;
        fetch_pc_s   = fetch_pc_r;
        drop_first_s = drop_first_r;
        i_valid_s    = i_valid_r;
        i_addr_s     = i_addr_r;
        deq_s        = 2'd0;
        mid_s        = count_r;

        if (redirect) begin
            count_s      = 3'd0;
            head_pc_s    = redirect_pc & 32'hFFFF_FFFE;
            fetch_pc_s   = redirect_pc & 32'hFFFF_FFFC;
            drop_first_s = redirect_pc[1];
            if (i_valid_r && !i_ready) begin
                // The bus still owes us a word; hold the request and throw it away later.
                state_s = DISCARD;
            end else if (state_r == DISCARD) begin
                state_s   = RUN;
                i_valid_s = 1'b1;
                i_addr_s  = redirect_pc & 32'hFFFF_FFFC;
            end else begin
                state_s   = RUN;
                i_valid_s = 1'b0;
            end
        end else if (state_r == DISCARD) begin
            if (i_ready) begin
                state_s   = RUN;
                i_valid_s = 1'b1;
                i_addr_s  = fetch_pc_r;
            end else begin
                state_s = DISCARD;
            end
        end else begin
            if (issue_s && inst_ready) begin
                if (head_c_s) begin
                    deq_s = 2'd1;
                end else begin
                    deq_s = 2'd2;
                end
            end else begin
                deq_s = 2'd0;
            end
            mid_s = count_r - {1'b0, deq_s};
            case (deq_s)
                2'd1:    q_s = '{q_r[1], q_r[2], q_r[3], 16'h0000};
                2'd2:    q_s = '{q_r[2], q_r[3], 16'h0000, 16'h0000};
                default: q_s = q_r;
            endcase
            head_pc_s = head_pc_r + {29'd0, deq_s, 1'b0};

            // Only one request is ever outstanding and it is issued with count<=2, so both slots fit.
            if (i_valid_r && i_ready) begin
                if (drop_first_r) begin
                    q_s[mid_s[1:0]] = i_rdata[31:16];
                    count_s         = mid_s + 3'd1;
                end else begin
                    q_s[mid_s[1:0]]         = i_rdata[15:0];
                    q_s[mid_s[1:0] + 2'd1]  = i_rdata[31:16];
                    count_s                 = mid_s + 3'd2;
                end
                drop_first_s = 1'b0;
                fetch_pc_s   = fetch_pc_r + 32'd4;
                i_valid_s    = 1'b0;
            end else begin
                count_s = mid_s;
                if (!i_valid_r && (count_r <= 3'd2)) begin
                    i_valid_s = 1'b1;
                    i_addr_s  = fetch_pc_r;
                end else begin
                    i_valid_s = i_valid_r;
                end
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= RUN;
            q_r          <= '{default: 16'h0000};
            count_r      <= 3'd0;
            head_pc_r    <= RESET_PC;
            fetch_pc_r   <= RESET_PC;
            drop_first_r <= 1'b0;
            i_valid_r    <= 1'b0;
            i_addr_r     <= RESET_PC;
        end else begin
            state_r      <= state_s;
            q_r          <= q_s;
            count_r      <= count_s;
            head_pc_r    <= head_pc_s;
            fetch_pc_r   <= fetch_pc_s;
            drop_first_r <= drop_first_s;
            i_valid_r    <= i_valid_s;
            i_addr_r     <= i_addr_s;
        end
    end

endmodule

// File: tb/tb_vigna_c_fetch_aligner.sv
// Bench for vigna_c_fetch_aligner: random-latency bus responder, instruction-stream
// reference model computed from memory contents, directed and randomized scenarios.
module tb_vigna_c_fetch_aligner;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        i_ready;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_is_c;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] req_log [$];
    int          bus_lat_min = 0;
    int          bus_lat_max = 0;
    bit          bus_hold    = 1'b0;
    logic [31:0] gd [$];
    logic [31:0] gp [$];
    logic        gc [$];

    vigna_c_fetch_aligner #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr), .i_rdata(i_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
        .inst_pc(inst_pc), .inst_is_c(inst_is_c)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] wa;
        wa = a & 32'hFFFF_FFFC;
        if (mem.exists(wa)) return mem[wa];
        return wa * 32'h9E37_79B1 + 32'h7F4A_7C15;
    endfunction

    function automatic logic [15:0] mem_hw(input logic [31:0] a);
        logic [31:0] w;
        w = mem_word(a);
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    // Instruction-stream view of memory: what should issue at pc, and where the next one starts.
    function automatic void ref_inst(input logic [31:0] pc, output logic [31:0] d,
                                     output logic c, output logic [31:0] nxt);
        logic [15:0] lo;
        lo = mem_hw(pc);
        if (lo[1:0] != 2'b11) begin
            d = {16'h0000, lo}; c = 1'b1; nxt = pc + 32'd2;
        end else begin
            d = {mem_hw(pc + 32'd2), lo}; c = 1'b0; nxt = pc + 32'd4;
        end
    endfunction

    // Bus responder: logs each new request, answers after a random latency unless held.
    initial begin
        bit pending;
        int wait_cnt;
        pending = 1'b0; wait_cnt = 0;
        i_ready = 1'b0; i_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (i_ready) begin
                i_ready = 1'b0;
                pending = 1'b0;
            end
            if (i_valid !== 1'b1) begin
                pending = 1'b0;
            end else begin
                if (!pending) begin
                    pending  = 1'b1;
                    wait_cnt = int'($urandom_range(bus_lat_max, bus_lat_min));
                    req_log.push_back(i_addr);
                end
                if (!bus_hold) begin
                    if (wait_cnt == 0) begin
                        i_ready = 1'b1;
                        i_rdata = mem_word(i_addr);
                    end else begin
                        wait_cnt--;
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One cycle: capture outputs at the negedge, drive inputs, advance to the next negedge.
    task automatic tick(input logic rdy, input logic redir, input logic [31:0] rpc,
                        output logic hs, output logic [31:0] d, output logic [31:0] p,
                        output logic c);
        d = inst_data; p = inst_pc; c = inst_is_c;
        inst_ready  = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        hs = (inst_valid === 1'b1) && rdy && !redir && (rst === 1'b0);
        @(posedge clk);
        @(negedge clk);
        redirect = 1'b0;
    endtask

    task automatic do_reset();
        logic hs, c;
        logic [31:0] d, p;
        rst = 1'b1;
        tick(1'b0, 1'b0, 32'd0, hs, d, p, c);
        tick(1'b0, 1'b0, 32'd0, hs, d, p, c);
        req_log.delete();
        rst = 1'b0;
    endtask

    task automatic collect(input int n, input int budget, input int ready_pct, output int got);
        logic hs, c;
        logic [31:0] d, p;
        gd.delete(); gp.delete(); gc.delete();
        got = 0;
        for (int k = 0; k < budget && got < n; k++) begin
            tick(($urandom_range(99, 0) < ready_pct), 1'b0, 32'd0, hs, d, p, c);
            if (hs) begin
                gd.push_back(d); gp.push_back(p); gc.push_back(c);
                got++;
            end
        end
    endtask

    task automatic test_reset();
        logic hs, c;
        logic [31:0] d, p;
        mem.delete();
        bus_lat_min = 0; bus_lat_max = 0;
        do_reset();
        total++;
        if (i_valid !== 1'b0 || inst_valid !== 1'b0 || i_addr !== RST_PC) begin
            bad++;
            $display("FAIL reset_state: i_valid=%b inst_valid=%b i_addr=%h, want 0 0 %h",
                     i_valid, inst_valid, i_addr, RST_PC);
        end
        tick(1'b0, 1'b0, 32'd0, hs, d, p, c);
        total++;
        if (i_valid !== 1'b1 || i_addr !== RST_PC) begin
            bad++;
            $display("FAIL first_request: i_valid=%b i_addr=%h, want 1 %h", i_valid, i_addr, RST_PC);
        end
    endtask

    task automatic test_aligned();
        logic hs, c;
        logic [31:0] d, p, r1;
        int got;
        mem.delete();
        mem[32'h0] = 32'h00a0_0093;
        bus_lat_min = 0; bus_lat_max = 0;
        do_reset();
        collect(1, 30, 100, got);
        total++;
        if (got != 1 || gd[0] !== 32'h00a0_0093 || gp[0] !== 32'h0 || gc[0] !== 1'b0) begin
            bad++;
            $display("FAIL aligned32: got=%0d data=%h pc=%h c=%b, want 1 00a00093 0 0",
                     got, gd[0], gp[0], gc[0]);
        end
        for (int k = 0; k < 4; k++) tick(1'b0, 1'b0, 32'd0, hs, d, p, c);
        r1 = (req_log.size() >= 2) ? req_log[1] : 32'hDEAD_BEEF;
        total++;
        if (r1 !== 32'h4) begin
            bad++;
            $display("FAIL next_fetch_addr: got=%h want=00000004", r1);
        end
    endtask

    task automatic test_two_c();
        int got;
        mem.delete();
        mem[32'h0] = 32'h40A9_40A9;
        bus_lat_min = 0; bus_lat_max = 1;
        do_reset();
        collect(2, 40, 100, got);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (gd[i] !== 32'h0000_40A9 || gp[i] !== 32'(2 * i) || gc[i] !== 1'b1) begin
                bad++;
                $display("FAIL two_c[%0d]: data=%h pc=%h c=%b, want 000040a9 %h 1",
                         i, gd[i], gp[i], gc[i], 32'(2 * i));
            end
        end
    endtask

    task automatic test_straddle();
        logic [31:0] ed [3];
        logic [31:0] ep [3];
        logic        ec [3];
        int got;
        ed = '{32'h0000_40A9, 32'h00a0_0093, 32'h0000_40A9};
        ep = '{32'h0, 32'h2, 32'h6};
        ec = '{1'b1, 1'b0, 1'b1};
        mem.delete();
        mem[32'h0] = 32'h0093_40A9;
        mem[32'h4] = 32'h40A9_00a0;
        bus_lat_min = 2; bus_lat_max = 2;
        do_reset();
        collect(3, 80, 100, got);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (gd[i] !== ed[i] || gp[i] !== ep[i] || gc[i] !== ec[i]) begin
                bad++;
                $display("FAIL straddle[%0d]: data=%h pc=%h c=%b, want %h %h %b",
                         i, gd[i], gp[i], gc[i], ed[i], ep[i], ec[i]);
            end
        end
    endtask

    task automatic test_misaligned_redirect();
        logic hs, c;
        logic [31:0] d, p;
        int got;
        mem.delete();
        mem[32'h100] = 32'h40A9_0001;
        bus_lat_min = 0; bus_lat_max = 2;
        do_reset();
        tick(1'b0, 1'b1, 32'h0000_0102, hs, d, p, c);
        collect(2, 60, 100, got);
        total++;
        if (gd[0] !== 32'h0000_40A9 || gp[0] !== 32'h102 || gc[0] !== 1'b1) begin
            bad++;
            $display("FAIL misaligned_first: data=%h pc=%h c=%b, want 000040a9 00000102 1",
                     gd[0], gp[0], gc[0]);
        end
        total++;
        if (gp[1] !== 32'h104) begin
            bad++;
            $display("FAIL misaligned_second_pc: got=%h want=00000104", gp[1]);
        end
    endtask

    task automatic test_redirect_stall();
        logic hs, c, ec;
        logic [31:0] d, p, ed, nxt, after8;
        int got, found;
        mem.delete();
        bus_lat_min = 3; bus_lat_max = 3;
        do_reset();
        found = 0;
        for (int k = 0; k < 60 && found == 0; k++) begin
            if (i_valid === 1'b1 && i_addr === 32'h8) begin
                bus_hold = 1'b1;
                found = 1;
            end else begin
                tick(1'b1, 1'b0, 32'd0, hs, d, p, c);
            end
        end
        total++;
        if (found == 0) begin
            bad++;
            $display("FAIL stall_reach_8: request at 00000008 never seen");
        end
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 1'b0, 32'd0, hs, d, p, c);
            total++;
            if (i_valid !== 1'b1 || i_addr !== 32'h8) begin
                bad++;
                $display("FAIL stall_hold[%0d]: i_valid=%b i_addr=%h, want 1 00000008", k, i_valid, i_addr);
            end
        end
        tick(1'b0, 1'b1, 32'h40, hs, d, p, c);
        for (int k = 0; k < 2; k++) begin
            tick(1'b1, 1'b0, 32'd0, hs, d, p, c);
            total++;
            if (i_valid !== 1'b1 || i_addr !== 32'h8 || inst_valid !== 1'b0 || hs) begin
                bad++;
                $display("FAIL discard_hold[%0d]: i_valid=%b i_addr=%h inst_valid=%b, want 1 00000008 0",
                         k, i_valid, i_addr, inst_valid);
            end
        end
        bus_hold = 1'b0;
        collect(2, 60, 100, got);
        ref_inst(32'h40, ed, ec, nxt);
        total++;
        if (got != 2 || gp[0] !== 32'h40 || gd[0] !== ed || gc[0] !== ec) begin
            bad++;
            $display("FAIL after_redirect: got=%0d data=%h pc=%h, want 2 %h 00000040", got, gd[0], gp[0], ed);
        end
        after8 = 32'hDEAD_BEEF;
        for (int i = 0; i + 1 < req_log.size(); i++)
            if (req_log[i] === 32'h8) after8 = req_log[i + 1];
        total++;
        if (after8 !== 32'h40) begin
            bad++;
            $display("FAIL request_after_discard: got=%h want=00000040", after8);
        end
    endtask

    task automatic test_backpressure();
        logic hs, c, ec;
        logic [31:0] d, p, ed, epc, nxt;
        int got, early;
        mem.delete();
        for (int a = 0; a < 64; a += 4)
            mem[32'(a)] = {2'b01, 14'(a + 2), 2'b01, 14'(a)};
        bus_lat_min = 0; bus_lat_max = 1;
        do_reset();
        early = 0;
        for (int k = 0; k < 20; k++) begin
            tick(1'b0, 1'b0, 32'd0, hs, d, p, c);
            if (hs) early++;
        end
        total++;
        if (i_valid !== 1'b0 || req_log.size() != 2 || inst_valid !== 1'b1 || early != 0) begin
            bad++;
            $display("FAIL full_queue: i_valid=%b requests=%0d inst_valid=%b, want 0 2 1",
                     i_valid, req_log.size(), inst_valid);
        end
        collect(12, 80, 100, got);
        total++;
        if (got != 12) begin
            bad++;
            $display("FAIL bp_count: got=%0d want=12", got);
        end
        epc = 32'h0;
        for (int i = 0; i < got; i++) begin
            ref_inst(epc, ed, ec, nxt);
            total++;
            if (gd[i] !== ed || gp[i] !== epc || gc[i] !== ec) begin
                bad++;
                $display("FAIL bp_order[%0d]: data=%h pc=%h, want %h %h", i, gd[i], gp[i], ed, epc);
            end
            epc = nxt;
        end
    endtask

    task automatic test_wrap();
        logic hs, c, ec;
        logic [31:0] d, p, ed, epc, nxt;
        int got;
        mem.delete();
        bus_lat_min = 0; bus_lat_max = 2;
        do_reset();
        tick(1'b0, 1'b1, 32'hFFFF_FFFA, hs, d, p, c);
        collect(4, 80, 70, got);
        total++;
        if (got != 4) begin
            bad++;
            $display("FAIL wrap_count: got=%0d want=4", got);
        end
        epc = 32'hFFFF_FFFA;
        for (int i = 0; i < got; i++) begin
            ref_inst(epc, ed, ec, nxt);
            total++;
            if (gd[i] !== ed || gp[i] !== epc || gc[i] !== ec) begin
                bad++;
                $display("FAIL wrap[%0d]: data=%h pc=%h, want %h %h", i, gd[i], gp[i], ed, epc);
            end
            epc = nxt;
        end
    endtask

    task automatic test_random();
        logic hs, c, ec, redir, redir_prev;
        logic [31:0] d, p, ed, epc, nxt, tgt;
        int n_hs;
        mem.delete();
        for (int a = 0; a < 1024; a += 4) mem[32'(a)] = $urandom;
        bus_lat_min = 0; bus_lat_max = 3;
        do_reset();
        epc = RST_PC; redir_prev = 1'b0; n_hs = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            redir = ($urandom_range(39, 0) == 0);
            tgt   = $urandom_range(1023, 0);
            if (redir_prev) begin
                total++;
                if (inst_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL valid_after_redirect: cycle=%0d inst_valid=%b want 0", cyc, inst_valid);
                end
            end
            tick(($urandom_range(99, 0) < 60), redir, tgt, hs, d, p, c);
            if (hs) begin
                ref_inst(epc, ed, ec, nxt);
                total++;
                if (d !== ed || p !== epc || c !== ec) begin
                    bad++;
                    $display("FAIL random_issue: cycle=%0d data=%h pc=%h c=%b, want %h %h %b",
                             cyc, d, p, c, ed, epc, ec);
                end
                epc = nxt;
                n_hs++;
            end
            if (redir) epc = tgt & 32'hFFFF_FFFE;
            redir_prev = redir;
        end
        total++;
        if (n_hs < 100) begin
            bad++;
            $display("FAIL random_progress: issued=%0d want>=100", n_hs);
        end
    endtask

    initial begin
        rst = 1'b1; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        @(negedge clk);
        test_reset();
        test_aligned();
        test_two_c();
        test_straddle();
        test_misaligned_redirect();
        test_redirect_stall();
        test_backpressure();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vigna_c_fetch_aligner.md
Name: vigna_c_fetch_aligner

Overview:
- Sits between the instruction bus and the RVC expander/decoder of the core.
- Fetches word-aligned 32-bit words into a 4-halfword parcel queue.
- Issues one instruction per handshake: either a 16-bit compressed parcel or a 32-bit instruction, which may straddle two fetched words.
- Handles control-flow redirects to any halfword-aligned target, including discard of an in-flight fetch.

Parameters:
- RESET_PC, 32'h0000_0000: first fetch address after reset. Bits [1:0] must be 0.

Ports:
- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- i_valid  out  1  fetch request valid
- i_ready  in  1  fetch response strobe; i_rdata valid this cycle; completes request
- i_addr  out  32  fetch address, bits [1:0] always 0
- i_rdata  in  32  fetched word, little-endian: [15:0] = halfword at i_addr
- redirect  in  1  flush and restart at redirect_pc
- redirect_pc  in  32  target, bit 0 ignored (treated 0)
- inst_valid  out  1  instruction available
- inst_ready  in  1  consumer accepts instruction
- inst_data  out  32  32-bit: full word; compressed: {16'h0000, parcel}
- inst_pc  out  32  address of the instruction's first halfword
- inst_is_c  out  1  1 when head parcel [1:0] != 2'b11

Behaviour:
- State: FSM {RUN, DISCARD}; queue of 4 halfwords with per-entry pc (or head pc + increment); count 0..4; fetch_pc; drop_first flag; registered i_valid.
- Reset (rst=1 at edge):
  - state=RUN, count=0, fetch_pc=RESET_PC, drop_first=0.
  - i_valid=0, inst_valid=0.
  - i_addr=RESET_PC.
- Fetch issue:
  - RUN with i_valid=0 and count<=2 (count before any same-cycle dequeue): set i_valid=1 next cycle with i_addr=fetch_pc.
  - First request appears the cycle after rst deasserts.
  - i_valid and i_addr stay stable until i_ready.
- Fetch complete (i_valid and i_ready, RUN, no redirect):
  - Enqueue low then high halfword. If drop_first=1, enqueue only the high halfword and clear drop_first.
  - fetch_pc += 4.
  - i_valid drops next cycle, then re-asserts only if the space rule still holds. One request outstanding at most.
- Issue (combinational from registered queue state):
  - Head [1:0] != 2'b11 with count>=1: inst_valid=1, inst_is_c=1.
  - Head [1:0] == 2'b11 with count>=2: inst_valid=1, inst_is_c=0, inst_data={entry1, entry0}.
  - Head 32-bit with count==1: inst_valid=0 (waiting for second half; straddle case).
  - Handshake dequeues 1 or 2 entries. Enqueue and dequeue in the same cycle are both honoured.
- Latency: data returned at cycle M → inst_valid at M+1 earliest.
- Redirect (priority over everything):
  - Queue flushed.
  - fetch_pc={redirect_pc[31:2],2'b00}; drop_first=redirect_pc[1].
  - Any inst handshake in that cycle is ignored.
  - If i_valid=1 and i_ready=0 that cycle: go to DISCARD. Keep the old i_addr and i_valid until i_ready, drop that data, then return to RUN; new request follows next cycle.
  - If i_ready=1 in the redirect cycle: the response is dropped, and the state stays RUN.
  - Redirect while in DISCARD: update fetch_pc and drop_first, stay in DISCARD.
- inst_valid never asserts in DISCARD, or in the cycle after redirect.
- Values on inst_data, inst_pc and inst_is_c are don't-care when inst_valid=0. i_addr is don't-care when i_valid=0.
- Reset mid-fetch: outstanding request abandoned. The bus model must tolerate i_valid dropping without i_ready.
- fetch_pc wraps modulo 2^32.

Test Plan:
- Aligned 32-bit: mem[0]=0x00a00093, inst_ready=1 → inst_data=0x00a00093, inst_pc=0, inst_is_c=0. Next fetch i_addr=4.
- Two compressed: mem[0]=0x40A9_40A9 → two issues of inst_data=0x0000_40A9, inst_is_c=1, at pc 0 then 2.
- Straddle: mem[0]=0x0093_40A9, mem[4]=0x40A9_00a0 → three issues in order:
  - C 0x40A9 @0
  - 0x00a00093 @2 (inst_valid held low until mem[4] arrives)
  - C 0x40A9 @6
- Misaligned redirect: redirect_pc=0x102, mem[0x100]=0x40A9_0001 → first output C 0x40A9 @0x102. Low half never issued.
- Redirect during stalled fetch: i_ready held low 3 cycles after request at 0x8, redirect to 0x40 → i_addr stays 0x8 until i_ready; that data is never issued; next request i_addr=0x40.
- Backpressure/full: inst_ready=0 with all-C words → count reaches 4, i_valid stays low. Release inst_ready → issues resume in order with no lost or duplicated parcels.
